circuito_jogo_seq: RTL and testbench

Parametrised sequence-memory game core, the next generation of the experiment-4 control unit plus datapath. It walks an internal sequence ROM of `DEPTH` entries and accepts one player move per key press on `N_CHAVES` switches. Each move is compared with the current ROM entry. The game ends in a hit (whole sequence matched) or a miss (first mismatch, or timeout when compiled in). It sits between the board switches/button and the 7-segment debug decoders, which are instantiated outside this block.

---
 rtl/circuito_jogo_seq.sv | 168 ++++++++++++++++
 tb/tb_circuito_jogo_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/circuito_jogo_seq.sv
// circuito_jogo_seq: sequence-memory game core.
// The core walks a fixed one-hot sequence ROM and compares it with the
// player's moves. A move is a rising press on the switches: at least one
// switch is set now, and no switch was set in the previous cycle.
// Optional build macro CIRCUITO_JOGO_SEQ_TIMEOUT_EN adds a per-move wait
// limit of TIMEOUT_CYCLES. This build makes fim_timeout reachable.
module circuito_jogo_seq #(
   parameter int N_CHAVES       = 4,
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         iniciar,
   input  logic [N_CHAVES-1:0]          chaves,
   output logic                         pronto,
   output logic                         acertou,
   output logic                         errou,
   output logic                         timeout,
   output logic                         db_igual,
   output logic                         db_iniciar,
   output logic [$clog2(DEPTH)-1:0]     db_contagem,
   output logic [N_CHAVES-1:0]          db_memoria,
   output logic [N_CHAVES-1:0]          db_jogada,
   output logic [3:0]                   db_estado
);

   localparam int CW = $clog2(DEPTH);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      COMPARA     = 4'h3,
      PROXIMO     = 4'h4,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   // Parameter values that would break the ROM or the timer are rejected
   // at elaboration.
   if (N_CHAVES < 2 || DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
      $error("circuito_jogo_seq: invalid parameters");
   end

   estado_t             estado_q, estado_d;
   logic [CW-1:0]       endereco_q, endereco_d;
   logic [N_CHAVES-1:0] jogada_q, jogada_d;
   logic [N_CHAVES-1:0] chavesPrev_q;
   logic [N_CHAVES-1:0] memoria;
   logic                jogadaNova;
   logic                limiteTempo;

   // ROM entry i has the single bit (i mod N_CHAVES) set.
   always_comb begin
      memoria = '0;
      for (int i = 0; i < N_CHAVES; i++) begin
         memoria[i] = ((int'(endereco_q) % N_CHAVES) == i);
      end
   end

   assign jogadaNova = (chaves != '0) && (chavesPrev_q == '0);

`ifdef CIRCUITO_JOGO_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer_q, timer_d;

   // The timer counts cycles spent in espera. It reads zero on every entry
   // into espera because every other state clears it.
   always_comb begin
      timer_d = '0;
      if (estado_q == ESPERA) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Timer register. It clears on synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign limiteTempo = (timer_q == TW'(TIMEOUT_CYCLES - 1));
   assign timeout     = (estado_q == FIM_TIMEOUT);
`else
   assign limiteTempo = 1'b0;
   assign timeout     = 1'b0;
`endif

   // State, address, last move and previous-switch registers. Reset has
   // priority over everything, so a press coinciding with reset is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q     <= INICIAL;
         endereco_q   <= '0;
         jogada_q     <= '0;
         chavesPrev_q <= '0;
      end else begin
         estado_q     <= estado_d;
         endereco_q   <= endereco_d;
         jogada_q     <= jogada_d;
         chavesPrev_q <= chaves;
      end
   end

   // Next-state logic. A move wins over the timeout limit in the same cycle.
   // Press edges outside espera are ignored, but chavesPrev_q still tracks
   // them. The address never wraps because the last entry ends the game.
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      jogada_d   = jogada_q;
      unique case (estado_q)
         INICIAL: begin
            if (iniciar) estado_d = PREPARACAO;
         end
         PREPARACAO: begin
            endereco_d = '0;
            jogada_d   = '0;
            estado_d   = ESPERA;
         end
         ESPERA: begin
            if (jogadaNova) begin
               jogada_d = chaves;
               estado_d = COMPARA;
            end else if (limiteTempo) begin
               estado_d = FIM_TIMEOUT;
            end
         end
         COMPARA: begin
            if (jogada_q != memoria) begin
               estado_d = FIM_ERRO;
            end else if (endereco_q == CW'(DEPTH - 1)) begin
               estado_d = FIM_ACERTO;
            end else begin
               estado_d = PROXIMO;
            end
         end
         PROXIMO: begin
            endereco_d = endereco_q + 1'b1;
            estado_d   = ESPERA;
         end
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (iniciar) estado_d = PREPARACAO;
         end
         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   assign pronto      = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) ||
                        (estado_q == FIM_TIMEOUT);
   assign acertou     = (estado_q == FIM_ACERTO);
   assign errou       = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
   assign db_igual    = (jogada_q == memoria);
   assign db_iniciar  = iniciar;
   assign db_contagem = endereco_q;
   assign db_memoria  = memoria;
   assign db_jogada   = jogada_q;
   assign db_estado   = estado_q;

endmodule

// File: tb/tb_circuito_jogo_seq.sv
// tb_circuito_jogo_seq: directed test of circuito_jogo_seq with
// N_CHAVES=4, DEPTH=4 (ROM 0001, 0010, 0100, 1000) and TIMEOUT_CYCLES=8.
module tb_circuito_jogo_seq;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] chaves;
   logic       pronto, acertou, errou, timeout, db_igual, db_iniciar;
   logic [1:0] db_contagem;
   logic [3:0] db_memoria, db_jogada, db_estado;

   int checks = 0;
   int errors = 0;

   circuito_jogo_seq #(
      .N_CHAVES(4),
      .DEPTH(4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .iniciar(iniciar),
      .chaves(chaves),
      .pronto(pronto),
      .acertou(acertou),
      .errou(errou),
      .timeout(timeout),
      .db_igual(db_igual),
      .db_iniciar(db_iniciar),
      .db_contagem(db_contagem),
      .db_memoria(db_memoria),
      .db_jogada(db_jogada),
      .db_estado(db_estado)
   );

   // Free-running clock with a 10-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One press: hold for 3 edges, then release for 2 edges.
   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] expResult,
                                input logic [3:0] expAfter, input logic [1:0] expAddr);
      chaves = v;
      tick();
      checkOutput("compara_estado", db_estado, 4'h3);
      checkOutput("compara_jogada", db_jogada, v);
      tick();
      checkOutput("resultado_estado", db_estado, expResult);
      tick();
      checkOutput("apos_estado", db_estado, expAfter);
      checkOutput("apos_contagem", db_contagem, expAddr);
      chaves = 4'h0;
      tick();
      tick();
   endtask

   // Directed scenario sequence.
   initial begin
      reset = 1'b1;
      iniciar = 1'b0;
      chaves = 4'h0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("reset_estado", db_estado, 4'h0);
      checkOutput("reset_pronto", pronto, 1'b0);
      checkOutput("reset_acertou", acertou, 1'b0);
      checkOutput("reset_errou", errou, 1'b0);
      checkOutput("reset_timeout", timeout, 1'b0);
      checkOutput("reset_contagem", db_contagem, 2'd0);
      checkOutput("reset_memoria", db_memoria, 4'b0001);
      checkOutput("reset_jogada", db_jogada, 4'h0);

      // Full correct sequence.
      iniciar = 1'b1;
      #1;
      checkOutput("db_iniciar", db_iniciar, 1'b1);
      tick();
      checkOutput("start_preparacao", db_estado, 4'h1);
      iniciar = 1'b0;
      tick();
      checkOutput("start_espera", db_estado, 4'h2);
      applyStimulus(4'b0001, 4'h4, 4'h2, 2'd1);
      applyStimulus(4'b0010, 4'h4, 4'h2, 2'd2);
      applyStimulus(4'b0100, 4'h4, 4'h2, 2'd3);
      applyStimulus(4'b1000, 4'hA, 4'hA, 2'd3);
      checkOutput("acerto_acertou", acertou, 1'b1);
      checkOutput("acerto_pronto", pronto, 1'b1);
      checkOutput("acerto_errou", errou, 1'b0);
      checkOutput("acerto_igual", db_igual, 1'b1);
      tick();
      tick();
      checkOutput("acerto_hold", db_estado, 4'hA);

      // Wrong third move.
      iniciar = 1'b1;
      tick();
      checkOutput("restart_preparacao", db_estado, 4'h1);
      iniciar = 1'b0;
      tick();
      checkOutput("restart_espera", db_estado, 4'h2);
      checkOutput("restart_contagem", db_contagem, 2'd0);
      checkOutput("restart_jogada", db_jogada, 4'h0);
      applyStimulus(4'b0001, 4'h4, 4'h2, 2'd1);
      applyStimulus(4'b0010, 4'h4, 4'h2, 2'd2);
      applyStimulus(4'b1000, 4'hE, 4'hE, 2'd2);
      checkOutput("erro_errou", errou, 1'b1);
      checkOutput("erro_acertou", acertou, 1'b0);
      checkOutput("erro_pronto", pronto, 1'b1);
      checkOutput("erro_jogada", db_jogada, 4'b1000);
      checkOutput("erro_memoria", db_memoria, 4'b0100);
      checkOutput("erro_igual", db_igual, 1'b0);
      checkOutput("erro_timeout", timeout, 1'b0);

      // Held switch counts as a single move; iniciar is ignored in espera.
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      checkOutput("hold_espera", db_estado, 4'h2);
      chaves = 4'b0001;
      tick();
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         iniciar = (i == 2);
         tick();
         checkOutput("hold_estado", db_estado, 4'h2);
         checkOutput("hold_contagem", db_contagem, 2'd1);
      end
      iniciar = 1'b0;
      chaves = 4'h0;
      tick();
      tick();

      // Second correct move, then reset aborts the game. The press that
      // coincides with reset is lost and stays held.
      applyStimulus(4'b0010, 4'h4, 4'h2, 2'd2);
      reset = 1'b1;
      chaves = 4'b0100;
      tick();
      reset = 1'b0;
      checkOutput("abort_estado", db_estado, 4'h0);
      checkOutput("abort_contagem", db_contagem, 2'd0);
      checkOutput("abort_jogada", db_jogada, 4'h0);
      checkOutput("abort_pronto", pronto, 1'b0);
      tick();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      tick();
      checkOutput("lost_move_espera", db_estado, 4'h2);
      chaves = 4'h0;
      tick();
      tick();
      applyStimulus(4'b0001, 4'h4, 4'h2, 2'd1);

      // Waiting without a move.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      checkOutput("wait_espera", db_estado, 4'h2);
`ifdef CIRCUITO_JOGO_SEQ_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         tick();
         checkOutput("wait_estado", db_estado, 4'h2);
      end
      tick();
      checkOutput("to_estado", db_estado, 4'hD);
      checkOutput("to_timeout", timeout, 1'b1);
      checkOutput("to_errou", errou, 1'b1);
      checkOutput("to_pronto", pronto, 1'b1);
      checkOutput("to_acertou", acertou, 1'b0);
`else
      for (int i = 0; i < 50; i++) begin
         tick();
         checkOutput("wait_estado", db_estado, 4'h2);
         checkOutput("wait_timeout", timeout, 1'b0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
